mmio_uart: RTL and testbench



---
 rtl/mmio_pkg.sv | 17 +
 rtl/mmio_uart_tx.sv | 86 ++++++++
 rtl/mmio_uart.sv | 89 ++++++++
 tb/tb_mmio_uart.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO slave: register map, status bits and the
// serial transmitter state encoding.
package mmio_pkg;
  localparam int IO_SEL_BIT = 22;
  localparam int FIFO_DEPTH = 4;

  localparam logic [2:0] REG_LEDS        = 3'd0;
  localparam logic [2:0] REG_UART_DATA   = 3'd1;
  localparam logic [2:0] REG_UART_STATUS = 3'd2;
  localparam logic [2:0] REG_CYCLES      = 3'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/mmio_uart_tx.sv
// 8N1 serial transmitter: pops one byte per frame from a valid/data source.
// txd is registered, so the line trails the FSM state by one cycle.
module uart_tx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       pop,
  output logic       busy,
  output logic       txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e      state, state_n;
  logic [CW-1:0]  baud_cnt, baud_n;
  logic [7:0]     shift, shift_n;
  logic [2:0]     bit_cnt, bit_n;
  logic           txd_n;
  logic           baud_last;

  assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      shift    <= shift_n;
      bit_cnt  <= bit_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    shift_n = shift;
    bit_n   = bit_cnt;
    pop     = 1'b0;
    txd_n   = 1'b1;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (valid) begin
          pop     = 1'b1;
          shift_n = data;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        txd_n = 1'b0;
        if (baud_last) begin
          baud_n  = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        txd_n = shift[0];
        if (baud_last) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/mmio_uart.sv
// MMIO slave on the core data bus: LED register, 4-deep UART TX FIFO,
// status register and a free-running cycle counter; read data is registered.
module mmio_uart
  import mmio_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] io_rdata,
  output logic [4:0]  leds,
  output logic        uart_txd
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  logic        io_en, wr, push, accept, fifo_pop, tx_busy, full, ovf;
  logic [2:0]  idx, count;
  logic [1:0]  wp, rp;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [31:0] cycles, rd_val, status;
  logic        unused_ok;

  assign io_en  = mem_addr[IO_SEL_BIT];
  assign idx    = mem_addr[4:2];
  assign wr     = io_en && (mem_wmask != 4'b0);
  assign push   = wr && (idx == REG_UART_DATA) && mem_wmask[0];
  assign full   = (count == 3'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign accept = push && (!full || fifo_pop);
  assign unused_ok = ^{mem_addr[31:23], mem_addr[21:5], mem_addr[1:0], mem_wdata[31:8]};

  always_comb begin
    status          = '0;
    status[ST_BUSY] = tx_busy || (count != 3'd0);
    status[ST_FULL] = full;
    status[ST_OVF]  = ovf;
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      REG_LEDS:        rd_val = {27'b0, leds};
      REG_UART_STATUS: rd_val = status;
      REG_CYCLES:      rd_val = cycles;
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= '0;
      leds     <= '0;
      cycles   <= '0;
      ovf      <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (io_en && mem_rstrb) io_rdata <= rd_val;
      if (wr && (idx == REG_LEDS) && mem_wmask[0]) leds <= mem_wdata[4:0];
      if (push && !accept) ovf <= 1'b1;
      else if (wr && (idx == REG_UART_STATUS)) ovf <= 1'b0;
      if (accept) wp <= wp + 2'd1;
      if (fifo_pop) rp <= rp + 2'd1;
      count <= count + {2'b0, accept} - {2'b0, fifo_pop};
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wp] <= mem_wdata[7:0];
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (count != 3'd0),
    .data  (fifo_mem[rp]),
    .pop   (fifo_pop),
    .busy  (tx_busy),
    .txd   (uart_txd)
  );
endmodule

// File: tb/tb_mmio_uart.sv
// Bench for mmio_uart: frame-level serial model checked every cycle, plus
// directed bus accesses with literal expectations and a serial decoder.
module tb_mmio_uart;
  localparam int C = 10;
  localparam logic [31:0] A_LEDS = 32'h0040_0000;
  localparam logic [31:0] A_DATA = 32'h0040_0004;
  localparam logic [31:0] A_STAT = 32'h0040_0008;
  localparam logic [31:0] A_CYC  = 32'h0040_000C;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_rstrb = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] io_rdata;
  logic [4:0]  leds;
  logic        uart_txd;

  mmio_uart #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .io_rdata(io_rdata),
    .leds(leds), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int vectors = 0, miscompares = 0;

  // Model: each accepted byte is a frame with a push edge and a start edge
  // (first edge after which the line is low).
  int         push_e[$], start_e[$];
  logic [7:0] byte_q[$];
  logic [4:0] m_leds = '0;
  logic       m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    push_e.delete(); start_e.delete(); byte_q.delete();
    m_leds = '0; m_ovf = 1'b0;
  endfunction

  function automatic void model_push(input int e, input logic [7:0] b);
    int occ = 0;
    int s;
    foreach (start_e[i]) if (start_e[i] - 1 > e) occ++;
    if (occ >= 4) begin
      m_ovf = 1'b1;
      return;
    end
    s = e + 2;
    if (start_e.size() > 0 && start_e[$] + 10*C + 1 > s) s = start_e[$] + 10*C + 1;
    push_e.push_back(e); start_e.push_back(s); byte_q.push_back(b);
  endfunction

  function automatic logic model_txd(input int k);
    int b;
    foreach (start_e[i]) begin
      if (k >= start_e[i] && k < start_e[i] + 10*C) begin
        b = (k - start_e[i]) / C;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return byte_q[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  // Status as seen after edge k.
  function automatic logic [31:0] model_status(input int k);
    int occ = 0;
    logic busy = 1'b0;
    foreach (start_e[i]) begin
      if (push_e[i] <= k && k < start_e[i] - 1 + 10*C) busy = 1'b1;
      if (push_e[i] <= k && start_e[i] - 1 > k) occ++;
    end
    return {29'b0, m_ovf, (occ == 4), busy};
  endfunction

  always @(negedge clk) begin
    check("txd", {31'b0, uart_txd}, {31'b0, rst_n ? model_txd(edge_n) : 1'b1});
    check("leds", {27'b0, leds}, {27'b0, rst_n ? m_leds : 5'h0});
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    int e;
    @(negedge clk);
    mem_addr = addr; mem_wdata = data; mem_wmask = mask;
    e = edge_n + 1;
    @(posedge clk);
    if (addr[22] && mask != 4'b0) begin
      case (addr[4:2])
        3'd0: if (mask[0]) m_leds = data[4:0];
        3'd1: if (mask[0]) model_push(e, data[7:0]);
        3'd2: m_ovf = 1'b0;
        default: ;
      endcase
    end
    #1 mem_wmask = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rd, output logic [31:0] mstat);
    @(negedge clk);
    mem_addr = addr; mem_rstrb = 1'b1;
    mstat = model_status(edge_n);
    @(posedge clk);
    #1 rd = io_rdata;
    mem_rstrb = 1'b0;
  endtask

  task automatic read_status(input string name, input logic [31:0] lit);
    logic [31:0] rd, ms;
    bus_read(A_STAT, rd, ms);
    check({name, "_model"}, rd, ms);
    check({name, "_lit"}, rd, lit);
  endtask

  task automatic rx_byte(output logic [7:0] b, output int wait_cnt);
    b = '0; wait_cnt = 0;
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (uart_txd !== 1'b0 && wait_cnt < 3000);
    if (wait_cnt >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL rx_timeout: got no start bit, expected one within 3000 cycles");
      return;
    end
    repeat (4) @(negedge clk);
    check("rx_start", {31'b0, uart_txd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = uart_txd;
    end
    repeat (C) @(negedge clk);
    check("rx_stop", {31'b0, uart_txd}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, ms, r1, r2;
    logic [7:0]  b;
    int          gap, lows;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_txd", {31'b0, uart_txd}, 32'd1);
    check("rst_leds", {27'b0, leds}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    read_status("stat_reset", 32'h0);
    bus_read(A_LEDS, rd, ms);
    check("leds_read_reset", rd, 32'h0);

    // 2: LED register
    bus_write(A_LEDS, 32'h15, 4'b0001);
    check("leds_written", {27'b0, leds}, 32'h15);
    bus_read(A_LEDS, rd, ms);
    check("leds_read", rd, 32'h15);
    @(posedge clk); #1;
    check("rdata_hold", io_rdata, 32'h15);
    bus_write(A_LEDS, 32'h0A, 4'b0010);
    check("leds_lane1", {27'b0, leds}, 32'h15);
    bus_write(32'h0000_0000, 32'h0A, 4'b0001);
    check("leds_no_sel", {27'b0, leds}, 32'h15);
    bus_read(32'h0000_000C, rd, ms);
    check("rdata_no_sel", rd, 32'h15);
    bus_read(A_DATA, rd, ms);
    check("data_read_zero", rd, 32'h0);
    bus_read(32'h0040_0014, rd, ms);
    check("reg5_read_zero", rd, 32'h0);

    // 3: single frame 0xA5
    bus_write(A_DATA, 32'hA5, 4'b0001);
    @(posedge clk); #1;
    check("txd_edge1", {31'b0, uart_txd}, 32'd1);
    @(posedge clk); #1;
    check("txd_edge2", {31'b0, uart_txd}, 32'd0);
    fork
      begin
        rx_byte(b, gap);
        check("rx_a5", {24'b0, b}, 32'hA5);
      end
      begin
        repeat (50) @(negedge clk);
        read_status("stat_busy", 32'h1);
      end
    join
    repeat (20) @(negedge clk);
    read_status("stat_idle", 32'h0);

    // 4: back-to-back bytes, full and overflow
    fork
      begin
        for (int i = 1; i <= 5; i++) bus_write(A_DATA, i, 4'b0001);
        read_status("stat_full", 32'h3);
        bus_write(A_DATA, 32'h06, 4'b0001);
        read_status("stat_ovf", 32'h7);
        bus_write(A_STAT, 32'h0, 4'b1111);
        read_status("stat_ovf_clr", 32'h3);
      end
      begin
        for (int j = 0; j < 5; j++) begin
          rx_byte(b, gap);
          check("rx_seq", {24'b0, b}, j + 1);
          if (j > 0) check("rx_gap", gap, 32'd7);
        end
      end
    join
    repeat (20) @(negedge clk);
    read_status("stat_drained", 32'h0);

    // 5: cycle counter
    bus_read(A_CYC, r1, ms);
    repeat (6) @(posedge clk);
    bus_read(A_CYC, r2, ms);
    check("cycles_diff", r2 - r1, 32'd7);
    @(negedge clk);
    force dut.cycles = 32'hFFFF_FFFE;
    mem_addr = A_CYC; mem_rstrb = 1'b1;
    #1 release dut.cycles;
    @(posedge clk); #1;
    check("cycles_pre", io_rdata, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    check("cycles_max", io_rdata, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("cycles_wrap", io_rdata, 32'h0);
    mem_rstrb = 1'b0;

    // 6: reset in the middle of the data bits
    bus_write(A_DATA, 32'h3C, 4'b0001);
    lows = 0;
    while (uart_txd !== 1'b0 && lows < 100) begin
      @(negedge clk);
      lows++;
    end
    check("pre_rst_start", {31'b0, uart_txd}, 32'd0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("txd_rst_now", {31'b0, uart_txd}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    read_status("stat_after_rst", 32'h0);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("no_frame_after_rst", lows, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
